// File: rtl/pipeline_pkg.sv
// Shared dispatch-stage types and sizing for the rename -> issue-queue path.
package pipeline_pkg;

  localparam int DISPATCH_WIDTH = 2;
  localparam int DISPATCH_DEPTH = 8;
  localparam int DISPATCH_UOP_W = 64;

  typedef struct packed {
    logic [31:0] inst;
    logic [15:0] pc_lo;
    logic [7:0]  prd;
    logic [7:0]  rob_idx;
  } dispatch_uop_t;

endpackage

// File: rtl/dispatch_buffer_chk.sv
// Protocol and invariant assertions for dispatch_buffer, observed at its boundary.
module dispatch_buffer_chk #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2,
  parameter int UOP_W = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1,
  parameter int NW    = $clog2(WIDTH + 1)
) (
  input logic                   clk,
  input logic                   a_rst_n,
  input logic                   flush_i,
  input logic [WIDTH-1:0]       rn_valid_i,
  input logic                   rn_ready_o,
  input logic [NW-1:0]          n_push_s,
  input logic [WIDTH-1:0]       iq_valid_o,
  input logic [WIDTH-1:0]       iq_ready_i,
  input logic [WIDTH*UOP_W-1:0] iq_uop_o,
  input logic [CNT_W-1:0]       count_o
);

  a_count_bound : assert property (@(posedge clk) disable iff (!a_rst_n)
    count_o <= CNT_W'(DEPTH));

  a_no_push_unready : assert property (@(posedge clk) disable iff (!a_rst_n)
    (n_push_s != '0) |-> rn_ready_o);

  // A legal valid vector is a run of ones from slot 0, so adding one clears every set bit.
  a_valid_prefix : assert property (@(posedge clk) disable iff (!a_rst_n)
    (rn_valid_i & (rn_valid_i + WIDTH'(1))) == '0);

  for (genvar k = 0; k < WIDTH; k++) begin : g_stable
    a_uop_stable : assert property (@(posedge clk) disable iff (!a_rst_n)
      (iq_valid_o[k] && !iq_ready_i[k] && !(iq_valid_o[0] && iq_ready_i[0]) && !flush_i)
      |=> $stable(iq_uop_o[k*UOP_W +: UOP_W]));
  end

endmodule

// File: rtl/dispatch_buffer_leading_ones_cnt.sv
// Counts contiguous set bits starting at bit 0; a clear bit ends the run.
module leading_ones_cnt #(
  parameter int WIDTH = 2,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic run_s;

  // Walk the slots oldest-first and stop at the first gap.
  always_comb begin
    cnt_o = '0;
    run_s = 1'b1;
    for (int k = 0; k < WIDTH; k++) begin
      if (run_s && vec_i[k]) begin
        cnt_o = cnt_o + CNT_W'(1);
      end else begin
        run_s = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dispatch_buffer.sv
// In-order ring buffer between rename and issue-queue allocation: all-or-nothing group
// push, oldest-first offer with prefix pop, and a flush that drops every entry.
module dispatch_buffer
  import pipeline_pkg::*;
#(
  parameter int DEPTH = DISPATCH_DEPTH,
  parameter int WIDTH = DISPATCH_WIDTH,
  parameter int UOP_W = DISPATCH_UOP_W
) (
  input  logic                       clk,
  input  logic                       a_rst_n,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           rn_valid_i,
  input  logic [WIDTH*UOP_W-1:0]     rn_uop_i,
  output logic                       rn_ready_o,
  output logic [WIDTH-1:0]           iq_valid_o,
  output logic [WIDTH*UOP_W-1:0]     iq_uop_o,
  input  logic [WIDTH-1:0]           iq_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NW    = $clog2(WIDTH + 1);

  logic [UOP_W-1:0] mem_q [DEPTH];
  logic [UOP_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, wr_idx_s;
  logic [CNT_W-1:0] count_q, count_d;
  logic [NW-1:0]    n_push_s, n_pop_s;
  logic             push_en_s;

  // Readiness uses the registered count only; pops this cycle do not lend space.
  assign rn_ready_o = ((CNT_W'(DEPTH) - count_q) >= CNT_W'(WIDTH));
  assign push_en_s  = rn_ready_o & ~flush_i;
  assign count_o    = count_q;

  for (genvar k = 0; k < WIDTH; k++) begin : g_offer
    assign iq_valid_o[k]                = (count_q > CNT_W'(k));
    assign iq_uop_o[k*UOP_W +: UOP_W]   = mem_q[head_q + PTR_W'(k)];
  end

  leading_ones_cnt #(.WIDTH(WIDTH), .CNT_W(NW)) u_push_cnt (
    .vec_i (rn_valid_i & {WIDTH{push_en_s}}),
    .cnt_o (n_push_s)
  );

  leading_ones_cnt #(.WIDTH(WIDTH), .CNT_W(NW)) u_pop_cnt (
    .vec_i (iq_valid_o & iq_ready_i),
    .cnt_o (n_pop_s)
  );

  // Next-state pointers, occupancy and storage writes; flush overrides push and pop.
  always_comb begin
    mem_d    = mem_q;
    wr_idx_s = tail_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        wr_idx_s = tail_q + PTR_W'(k);
        if (NW'(k) < n_push_s) begin
          mem_d[wr_idx_s] = rn_uop_i[k*UOP_W +: UOP_W];
        end else begin
          mem_d[wr_idx_s] = mem_q[wr_idx_s];
        end
      end
      tail_d  = tail_q + PTR_W'(n_push_s);
      head_d  = head_q + PTR_W'(n_pop_s);
      count_d = count_q + CNT_W'(n_push_s) - CNT_W'(n_pop_s);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage is never reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  dispatch_buffer_chk #(.DEPTH(DEPTH), .WIDTH(WIDTH), .UOP_W(UOP_W)) u_chk (
    .clk        (clk),
    .a_rst_n    (a_rst_n),
    .flush_i    (flush_i),
    .rn_valid_i (rn_valid_i),
    .rn_ready_o (rn_ready_o),
    .n_push_s   (n_push_s),
    .iq_valid_o (iq_valid_o),
    .iq_ready_i (iq_ready_i),
    .iq_uop_o   (iq_uop_o),
    .count_o    (count_o)
  );

endmodule

// File: tb/tb_dispatch_buffer.sv
// Directed bench for dispatch_buffer: fill, partial pop, wrap, flush and async reset.
module tb_dispatch_buffer;
  import pipeline_pkg::*;

  logic         clk;
  logic         a_rst_n;
  logic         flush_i;
  logic [1:0]   rn_valid_i;
  logic [127:0] rn_uop_i;
  logic         rn_ready_o;
  logic [1:0]   iq_valid_o;
  logic [127:0] iq_uop_o;
  logic [1:0]   iq_ready_i;
  logic [3:0]   count_o;

  int n_cmp = 0;
  int n_err = 0;

  dispatch_buffer #(.DEPTH(8), .WIDTH(2), .UOP_W(64)) dut (
    .clk        (clk),
    .a_rst_n    (a_rst_n),
    .flush_i    (flush_i),
    .rn_valid_i (rn_valid_i),
    .rn_uop_i   (rn_uop_i),
    .rn_ready_o (rn_ready_o),
    .iq_valid_o (iq_valid_o),
    .iq_uop_o   (iq_uop_o),
    .iq_ready_i (iq_ready_i),
    .count_o    (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input int id);
    dispatch_uop_t u;
    u.inst    = 32'hC0DE_0000 + 32'(id);
    u.pc_lo   = 16'(id * 4);
    u.prd     = 8'(id);
    u.rob_idx = 8'(id + 1);
    return u;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input int a, input int b, input logic [1:0] r);
    rn_valid_i = v;
    rn_uop_i   = {mk(b), mk(a)};
    iq_ready_i = r;
  endtask

  task automatic idle();
    rn_valid_i = 2'b00;
    iq_ready_i = 2'b00;
    flush_i    = 1'b0;
  endtask

  initial begin
    a_rst_n = 1'b0;
    idle();
    rn_uop_i = '0;
    #12;
    check_eq("rst_valid", 64'(iq_valid_o), 64'd0);
    check_eq("rst_ready", 64'(rn_ready_o), 64'd1);
    check_eq("rst_count", 64'(count_o), 64'd0);
    @(negedge clk);
    a_rst_n = 1'b1;
    tick();
    check_eq("idle_valid", 64'(iq_valid_o), 64'd0);
    check_eq("idle_count", 64'(count_o), 64'd0);

    // Push A,B then observe them one cycle later.
    drive(2'b11, 10, 11, 2'b00);
    tick();
    idle();
    check_eq("ab_valid", 64'(iq_valid_o), 64'd3);
    check_eq("ab_uop0", iq_uop_o[63:0], mk(10));
    check_eq("ab_uop1", iq_uop_o[127:64], mk(11));
    check_eq("ab_count", 64'(count_o), 64'd2);

    // Fill to eight; readiness holds through count 6.
    for (int g = 1; g < 4; g++) begin
      check_eq("fill_ready", 64'(rn_ready_o), 64'd1);
      drive(2'b11, 10 + 2 * g, 11 + 2 * g, 2'b00);
      tick();
    end
    idle();
    check_eq("full_count", 64'(count_o), 64'd8);
    check_eq("full_ready", 64'(rn_ready_o), 64'd0);
    check_eq("full_uop0", iq_uop_o[63:0], mk(10));

    iq_ready_i = 2'b01;
    tick();
    check_eq("c7_count", 64'(count_o), 64'd7);
    check_eq("c7_ready", 64'(rn_ready_o), 64'd0);
    check_eq("c7_uop0", iq_uop_o[63:0], mk(11));
    iq_ready_i = 2'b11;
    tick();
    tick();
    iq_ready_i = 2'b10;
    check_eq("c3_count", 64'(count_o), 64'd3);
    tick();
    check_eq("gap_count", 64'(count_o), 64'd3);
    check_eq("gap_uop0", iq_uop_o[63:0], mk(15));
    iq_ready_i = 2'b01;
    tick();
    check_eq("p1_count", 64'(count_o), 64'd2);
    check_eq("p1_uop0", iq_uop_o[63:0], mk(16));
    check_eq("p1_uop1", iq_uop_o[127:64], mk(17));
    iq_ready_i = 2'b11;
    tick();
    check_eq("drain_valid", 64'(iq_valid_o), 64'd0);

    // Streaming: push one group and pop one group every cycle across several wraps.
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        check_eq("wrap_uop0", iq_uop_o[63:0], mk(100 + 2 * (i - 1)));
        check_eq("wrap_uop1", iq_uop_o[127:64], mk(101 + 2 * (i - 1)));
      end
      check_eq("wrap_count", 64'(count_o), (i == 0) ? 64'd0 : 64'd2);
      drive(2'b11, 100 + 2 * i, 101 + 2 * i, 2'b11);
      tick();
    end
    rn_valid_i = 2'b00;
    check_eq("wrap_last0", iq_uop_o[63:0], mk(138));
    check_eq("wrap_last1", iq_uop_o[127:64], mk(139));
    tick();
    check_eq("wrap_empty", 64'(count_o), 64'd0);

    // Flush at count 6 with a simultaneous push and pop.
    for (int g = 0; g < 3; g++) begin
      drive(2'b11, 200 + 2 * g, 201 + 2 * g, 2'b00);
      tick();
    end
    check_eq("c6_count", 64'(count_o), 64'd6);
    check_eq("c6_ready", 64'(rn_ready_o), 64'd1);
    check_eq("c6_uop0", iq_uop_o[63:0], mk(200));
    drive(2'b11, 300, 301, 2'b11);
    flush_i = 1'b1;
    tick();
    idle();
    check_eq("fl_count", 64'(count_o), 64'd0);
    check_eq("fl_valid", 64'(iq_valid_o), 64'd0);
    check_eq("fl_ready", 64'(rn_ready_o), 64'd1);
    drive(2'b11, 400, 401, 2'b00);
    tick();
    idle();
    check_eq("post_fl_uop0", iq_uop_o[63:0], mk(400));
    check_eq("post_fl_uop1", iq_uop_o[127:64], mk(401));
    check_eq("post_fl_count", 64'(count_o), 64'd2);

    // Asynchronous reset in the middle of a cycle.
    #3;
    a_rst_n = 1'b0;
    #1;
    check_eq("arst_count", 64'(count_o), 64'd0);
    check_eq("arst_valid", 64'(iq_valid_o), 64'd0);
    check_eq("arst_ready", 64'(rn_ready_o), 64'd1);
    @(negedge clk);
    a_rst_n = 1'b1;
    tick();
    check_eq("arst_hold", 64'(count_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
